imm_disp_extract_pipe: RTL and testbench

- Decode-stage extractor that pulls the immediate and displacement fields out of the raw instruction buffer in a single pass.
- Little-endian assembly of each field from a byte offset and size, then sign- or zero-extension to OUT_W.
- Result is registered behind a 2-entry skid buffer with valid/ready handshakes on both sides, so decode stalls do not drop or duplicate fields.
- Sits between the length decoder (which supplies offsets, sizes and opcode) and the decode/register-read pipeline latch.

---
 rtl/imm_disp_extract_pipe_if.sv | 36 +++
 rtl/imm_disp_extract_pipe.sv | 131 +++++++++++++
 tb/tb_imm_disp_extract_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_disp_extract_pipe_if.sv
// Handshake bundle between the length decoder, the imm/disp extractor and the
// decode pipeline latch.
interface imm_disp_extract_pipe_if #(
   parameter int IR_BYTES = 16,
   parameter int OUT_W    = 32,
   parameter int OFF_W    = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*IR_BYTES-1:0] IR;
   logic [15:0]           opcode;
   logic [OFF_W-1:0]      imm_off;
   logic [1:0]            imm_size;
   logic                  imm_en;
   logic [OFF_W-1:0]      disp_off;
   logic [1:0]            disp_size;
   logic                  disp_en;
   logic                  sx_force;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_W-1:0]      imm_out;
   logic [OUT_W-1:0]      disp_out;
   logic                  range_err;

   modport master (
      output in_valid, IR, opcode, imm_off, imm_size, imm_en,
             disp_off, disp_size, disp_en, sx_force, out_ready,
      input  in_ready, out_valid, imm_out, disp_out, range_err
   );

   modport slave (
      input  in_valid, IR, opcode, imm_off, imm_size, imm_en,
             disp_off, disp_size, disp_en, sx_force, out_ready,
      output in_ready, out_valid, imm_out, disp_out, range_err
   );
endinterface

// File: rtl/imm_disp_extract_pipe.sv
// Extracts and extends the immediate and displacement fields of an instruction,
// buffered behind a 2-entry skid so decode stalls never drop or repeat fields.
module imm_disp_extract_pipe #(
   parameter int IR_BYTES = 16,
   parameter int OUT_W    = 32,
   parameter int OFF_W    = 4
) (
   input logic                      clk,
   input logic                      reset,
   imm_disp_extract_pipe_if.slave   bus
);
   localparam int IW = (IR_BYTES > 1) ? $clog2(IR_BYTES) : 1;
   localparam int SW = OFF_W + 3;

   typedef struct packed {
      logic [OUT_W-1:0] imm;
      logic [OUT_W-1:0] disp;
      logic             err;
   } entry_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t state_q, state_d;
   entry_t or_q, or_d, sk_q, sk_d, new_e;
   logic   xfer_in, xfer_out;

   // irb[k] is instruction byte k; byte 0 sits at the MSB end of IR.
   logic [IR_BYTES-1:0][7:0] irb;
   for (genvar k = 0; k < IR_BYTES; k++) begin : g_byte
      assign irb[k] = bus.IR[8*IR_BYTES-1-8*k -: 8];
   end

   function automatic logic [SW-1:0] nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? SW'(1) : (sz == 2'b01) ? SW'(2) : SW'(4);
   endfunction

   // Little-endian gather; bytes past the end of the buffer read as zero.
   function automatic logic [31:0] gather(input logic [IR_BYTES-1:0][7:0] b,
                                          input logic [OFF_W-1:0] off,
                                          input logic [1:0] sz);
      logic [31:0]   f;
      logic [SW-1:0] idx;
      f = '0;
      for (int j = 0; j < 4; j++) begin
         idx = {3'b000, off} + SW'(j);
         if (SW'(j) < nbytes(sz) && idx < SW'(IR_BYTES))
            f[8*j +: 8] = b[idx[IW-1:0]];
      end
      return f;
   endfunction

   function automatic logic [OUT_W-1:0] extend(input logic [31:0] f,
                                               input logic [1:0] sz,
                                               input logic sx);
      logic [OUT_W-1:0] r;
      case (sz)
         2'b00:   r = sx ? OUT_W'($signed(f[7:0]))  : OUT_W'(f[7:0]);
         2'b01:   r = sx ? OUT_W'($signed(f[15:0])) : OUT_W'(f[15:0]);
         default: r = sx ? OUT_W'($signed(f))       : OUT_W'(f);
      endcase
      return r;
   endfunction

   function automatic logic overrun(input logic [OFF_W-1:0] off, input logic [1:0] sz);
      return ({3'b000, off} + nbytes(sz)) > SW'(IR_BYTES);
   endfunction

   logic imm_sx;
   always_comb begin
      // Only the short-form sign-extending ALU immediates (push imm8, imul imm8, grp1 imm8).
      imm_sx = bus.sx_force ||
               (bus.imm_size == 2'b00 && bus.opcode[15:8] == 8'h00 &&
                (bus.opcode[7:0] == 8'h6A || bus.opcode[7:0] == 8'h6B ||
                 bus.opcode[7:0] == 8'h83));
      new_e.imm  = bus.imm_en  ? extend(gather(irb, bus.imm_off, bus.imm_size), bus.imm_size, imm_sx)
                               : '0;
      new_e.disp = bus.disp_en ? extend(gather(irb, bus.disp_off, bus.disp_size), bus.disp_size, 1'b1)
                               : '0;
      new_e.err  = (bus.imm_en  && overrun(bus.imm_off,  bus.imm_size)) ||
                   (bus.disp_en && overrun(bus.disp_off, bus.disp_size));
   end

   // in_ready depends only on registered state (and reset), never on out_ready.
   assign bus.in_ready  = ~reset && (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.imm_out   = or_q.imm;
   assign bus.disp_out  = or_q.disp;
   assign bus.range_err = or_q.err;

   assign xfer_in  = bus.in_valid  && bus.in_ready;
   assign xfer_out = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      or_d    = or_q;
      sk_d    = sk_q;
      case (state_q)
         EMPTY: if (xfer_in) begin
            or_d    = new_e;
            state_d = ONE;
         end
         ONE: begin
            if (xfer_in && xfer_out) begin
               or_d = new_e;
            end else if (xfer_in) begin
               sk_d    = new_e;
               state_d = FULL;
            end else if (xfer_out) begin
               state_d = EMPTY;
            end
         end
         FULL: if (xfer_out) begin
            or_d    = sk_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         or_q    <= '0;
         sk_q    <= '0;
      end else begin
         state_q <= state_d;
         or_q    <= or_d;
         sk_q    <= sk_d;
      end
   end
endmodule

// File: tb/tb_imm_disp_extract_pipe.sv
// Directed bench for imm_disp_extract_pipe: a byte-level FIFO model checked every
// cycle, plus literal expectations for the hand-worked cases.
module tb_imm_disp_extract_pipe;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imm_disp_extract_pipe_if #(.IR_BYTES(16), .OUT_W(32), .OFF_W(4)) bus ();

   imm_disp_extract_pipe #(.IR_BYTES(16), .OUT_W(32), .OFF_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] imm;
      logic [31:0] disp;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   armed = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int byte_at(logic [127:0] ir, int k);
      if (k >= 16) return 0;
      return int'(ir[127-8*k -: 8]);
   endfunction

   function automatic int nb(logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Numeric value of the field, optionally reinterpreted as two's complement.
   function automatic logic [31:0] fld(logic [127:0] ir, int off, int n, bit sx);
      longint v = 0;
      for (int j = 0; j < n; j++) v += longint'(byte_at(ir, off + j)) * (longint'(1) << (8*j));
      if (sx && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   function automatic exp_t model();
      exp_t e;
      int   ni = nb(bus.imm_size);
      int   nd = nb(bus.disp_size);
      bit   sx = bus.sx_force ||
                 (ni == 1 && (bus.opcode == 16'h006A || bus.opcode == 16'h006B ||
                              bus.opcode == 16'h0083));
      e.imm  = bus.imm_en  ? fld(bus.IR, int'(bus.imm_off), ni, sx) : 32'h0;
      e.disp = bus.disp_en ? fld(bus.IR, int'(bus.disp_off), nd, 1'b1) : 32'h0;
      e.err  = (bus.imm_en  && int'(bus.imm_off)  + ni > 16) ||
               (bus.disp_en && int'(bus.disp_off) + nd > 16);
      return e;
   endfunction

   // Per-cycle compare against the model, then predict the coming edge.
   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", 32'(bus.in_ready), 32'(!reset && q.size() < 2));
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         if (q.size() != 0 && bus.out_valid) begin
            chk("model_imm", bus.imm_out, q[0].imm);
            chk("model_disp", bus.disp_out, q[0].disp);
            chk("model_err", 32'(bus.range_err), 32'(q[0].err));
         end
         if (reset) q.delete();
         else begin
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) q.push_back(model());
         end
      end
   end

   task automatic setb(int k, logic [7:0] v);
      bus.IR[127-8*k -: 8] = v;
   endtask

   task automatic clear_req();
      bus.IR = '0; bus.opcode = '0; bus.imm_off = '0; bus.imm_size = '0; bus.imm_en = 0;
      bus.disp_off = '0; bus.disp_size = '0; bus.disp_en = 0; bus.sx_force = 0;
   endtask

   // Present the current request until accepted; returns just after the accepting edge.
   task automatic send();
      bit ok = 0;
      bus.in_valid = 1;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk); #1;
      end
      bus.in_valid = 0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_out(string name, logic [31:0] imm, logic [31:0] disp, logic err);
      @(negedge clk);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_imm"}, bus.imm_out, imm);
      chk({name, "_disp"}, bus.disp_out, disp);
      chk({name, "_err"}, 32'(bus.range_err), 32'(err));
   endtask

   logic [31:0] seq_exp [3];

   initial begin
      bus.in_valid = 0; bus.out_ready = 1;
      clear_req();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      reset = 0;
      armed = 1;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_imm", bus.imm_out, 32'h0);
      chk("rst_disp", bus.disp_out, 32'h0);
      chk("rst_err", 32'(bus.range_err), 32'd0);
      @(posedge clk); #1;

      // grp1 imm8 sign-extended
      clear_req(); setb(0, 8'h83); setb(1, 8'hC0); setb(2, 8'hF0);
      bus.opcode = 16'h0083; bus.imm_off = 2; bus.imm_en = 1;
      send(); expect_out("sx83", 32'hFFFFFFF0, 32'h0, 0);

      // mov imm32
      clear_req(); setb(0, 8'hB8); setb(1, 8'h78); setb(2, 8'h56); setb(3, 8'h34); setb(4, 8'h12);
      bus.opcode = 16'h00B8; bus.imm_off = 1; bus.imm_size = 2'b10; bus.imm_en = 1;
      send(); expect_out("imm32", 32'h12345678, 32'h0, 0);

      // imm8 zero-extended for a non-sign-extending opcode
      setb(1, 8'h80); bus.imm_size = 2'b00;
      send(); expect_out("zx8", 32'h00000080, 32'h0, 0);

      // sx_force on a 16-bit immediate
      setb(1, 8'h34); setb(2, 8'h92); bus.imm_size = 2'b01; bus.sx_force = 1;
      send(); expect_out("sx16", 32'hFFFF9234, 32'h0, 0);

      // disp8 only
      clear_req(); setb(2, 8'hFE); bus.disp_en = 1; bus.disp_off = 2;
      send(); expect_out("disp8", 32'h0, 32'hFFFFFFFE, 0);

      // disp16 with an imm8 alongside
      clear_req(); setb(3, 8'h00); setb(4, 8'h80); setb(5, 8'h7F);
      bus.disp_en = 1; bus.disp_off = 3; bus.disp_size = 2'b01;
      bus.imm_en = 1; bus.imm_off = 5; bus.opcode = 16'h006A;
      send(); expect_out("disp16", 32'h0000007F, 32'hFFFF8000, 0);

      // imm32 at offset 14 overruns the 16-byte buffer
      clear_req(); setb(14, 8'hAB); setb(15, 8'hCD);
      bus.imm_off = 14; bus.imm_size = 2'b10; bus.imm_en = 1;
      send(); expect_out("overrun", 32'h0000CDAB, 32'h0, 1);

      // exact fit at the end is not an overrun
      clear_req(); setb(12, 8'h01); setb(13, 8'h02); setb(14, 8'h03); setb(15, 8'h84);
      bus.disp_off = 12; bus.disp_size = 2'b11; bus.disp_en = 1;
      send(); expect_out("fit_end", 32'h0, 32'h84030201, 0);
      @(posedge clk); #1;

      // Backpressure: A and B fill both slots, C waits upstream.
      bus.out_ready = 0;
      seq_exp[0] = 32'h000000A1; seq_exp[1] = 32'h000000B2; seq_exp[2] = 32'h000000C3;
      clear_req(); bus.imm_en = 1; bus.imm_off = 1;
      setb(1, 8'hA1); send();
      setb(1, 8'hB2); send();
      setb(1, 8'hC3); bus.in_valid = 1;
      @(negedge clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_head", bus.imm_out, seq_exp[0]);
      @(posedge clk); #1;
      bus.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         bit acc;
         @(negedge clk);
         chk("drain_valid", 32'(bus.out_valid), 32'd1);
         chk("drain_imm", bus.imm_out, seq_exp[i]);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) bus.in_valid = 0;
      end
      @(negedge clk);
      chk("drained_empty", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;

      // Reset while FULL discards both entries.
      bus.out_ready = 0;
      setb(1, 8'h11); send();
      setb(1, 8'h22); send();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst2_imm", bus.imm_out, 32'h0);
      chk("rst2_disp", bus.disp_out, 32'h0);
      chk("rst2_err", 32'(bus.range_err), 32'd0);
      bus.out_ready = 1;
      repeat (4) begin
         @(negedge clk);
         chk("rst2_stays_empty", 32'(bus.out_valid), 32'd0);
      end
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
